// File: rtl/lookup_table_multi_read.sv
// Two-channel lookup table: bursts a table from the databus into an external dual-port RAM,
// then serves two 1-cycle-latency lookup channels from it, optionally ping-pong double-buffered.
module lookup_table_multi_read #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  output logic                    done,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [LEN_W-1:0]        length,
  input  logic                    pingPong,
  input  logic                    disabled,
  input  logic [ADDR_W-1:0]       in0,
  input  logic [ADDR_W-1:0]       in1,
  output logic [DATA_W-1:0]       out0,
  output logic [DATA_W-1:0]       out1,
  output logic                    out0_valid,
  output logic                    out1_valid,
  output logic                    databus_valid_0,
  input  logic                    databus_ready_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic                    databus_last_0,
  output logic [ADDR_W-1:0]       ext_dp_addr_0_port_0,
  output logic [DATA_W-1:0]       ext_dp_out_0_port_0,
  input  logic [DATA_W-1:0]       ext_dp_in_0_port_0,
  output logic                    ext_dp_enable_0_port_0,
  output logic                    ext_dp_write_0_port_0,
  output logic [ADDR_W-1:0]       ext_dp_addr_0_port_1,
  output logic [DATA_W-1:0]       ext_dp_out_0_port_1,
  input  logic [DATA_W-1:0]       ext_dp_in_0_port_1,
  output logic                    ext_dp_enable_0_port_1,
  output logic                    ext_dp_write_0_port_1
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
  logic [LEN_W-1:0]        cfg_len_q, cfg_len_d;
  logic                    cfg_pp_q, cfg_pp_d;
  logic                    sel_q, sel_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    out0_vld_q, out1_vld_q;
  logic [DATA_W-1:0]       out0_hold_q, out1_hold_q;

  logic                    beat;
  logic [ADDR_W-1:0]       wr_addr, rd0_addr, rd1_addr;

  // A beat is only accepted while loading; reset masks it so the RAM sees no write
  assign beat = (state_q == LOAD) && databus_ready_0 && !rst;

  assign wr_addr  = cfg_pp_q ? {sel_q, cnt_q[ADDR_W-2:0]} : cnt_q;
  assign rd0_addr = cfg_pp_q ? {~sel_q, in0[ADDR_W-2:0]} : in0;
  assign rd1_addr = cfg_pp_q ? {~sel_q, in1[ADDR_W-2:0]} : in1;

  always_comb begin
    state_d    = state_q;
    cfg_addr_d = cfg_addr_q;
    cfg_len_d  = cfg_len_q;
    cfg_pp_d   = cfg_pp_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (run && !disabled) begin
          state_d    = LOAD;
          cfg_addr_d = ext_addr;
          cfg_len_d  = length;
          cfg_pp_d   = pingPong;
          cnt_d      = '0;
          if (pingPong) sel_d = ~sel_q;
        end
      end
      LOAD: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_ONE;
          if (databus_last_0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_addr_q  <= '0;
      cfg_len_q   <= '0;
      cfg_pp_q    <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      out0_vld_q  <= 1'b0;
      out1_vld_q  <= 1'b0;
      out0_hold_q <= '0;
      out1_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_len_q   <= cfg_len_d;
      cfg_pp_q    <= cfg_pp_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out0_vld_q  <= running;
      out1_vld_q  <= running && !beat;
      out0_hold_q <= out0;
      out1_hold_q <= out1;
    end
  end

  assign done            = (state_q == IDLE);
  assign databus_valid_0 = (state_q == LOAD);
  assign databus_addr_0  = cfg_addr_q;
  assign databus_len_0   = cfg_len_q;
  assign databus_wdata_0 = '0;
  assign databus_wstrb_0 = '0;

  // Port 0 is shared: the load write wins, channel 1 reads only in free cycles
  assign ext_dp_addr_0_port_0   = beat ? wr_addr : rd1_addr;
  assign ext_dp_out_0_port_0    = databus_rdata_0;
  assign ext_dp_enable_0_port_0 = beat || (running && !rst);
  assign ext_dp_write_0_port_0  = beat;

  assign ext_dp_addr_0_port_1   = rd0_addr;
  assign ext_dp_out_0_port_1    = '0;
  assign ext_dp_enable_0_port_1 = running && !rst;
  assign ext_dp_write_0_port_1  = 1'b0;

  assign out0       = out0_vld_q ? ext_dp_in_0_port_1 : out0_hold_q;
  assign out1       = out1_vld_q ? ext_dp_in_0_port_0 : out1_hold_q;
  assign out0_valid = out0_vld_q;
  assign out1_valid = out1_vld_q;

endmodule

// File: tb/tb_lookup_table_multi_read.sv
// Bench for lookup_table_multi_read: behavioural table model, bus/RAM environment, scoreboarded lookups.
module tb_lookup_table_multi_read;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int HALF  = 16;
  localparam int LW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, running, done, pingPong, disabled;
  logic [31:0] ext_addr;
  logic [LW-1:0] length;
  logic [AW-1:0] in0, in1;
  logic [31:0] out0, out1;
  logic out0_valid, out1_valid;
  logic databus_valid_0, databus_ready_0, databus_last_0;
  logic [31:0] databus_addr_0, databus_rdata_0, databus_wdata_0;
  logic [3:0] databus_wstrb_0;
  logic [LW-1:0] databus_len_0;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0] p0_wd, p1_wd, p0_rd, p1_rd;
  logic p0_en, p0_we, p1_en, p1_we;

  lookup_table_multi_read #(
    .DATA_W(32), .ADDR_W(AW), .AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done),
    .ext_addr(ext_addr), .length(length), .pingPong(pingPong), .disabled(disabled),
    .in0(in0), .in1(in1), .out0(out0), .out1(out1),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .databus_valid_0(databus_valid_0), .databus_ready_0(databus_ready_0),
    .databus_addr_0(databus_addr_0), .databus_rdata_0(databus_rdata_0),
    .databus_wdata_0(databus_wdata_0), .databus_wstrb_0(databus_wstrb_0),
    .databus_len_0(databus_len_0), .databus_last_0(databus_last_0),
    .ext_dp_addr_0_port_0(p0_addr), .ext_dp_out_0_port_0(p0_wd), .ext_dp_in_0_port_0(p0_rd),
    .ext_dp_enable_0_port_0(p0_en), .ext_dp_write_0_port_0(p0_we),
    .ext_dp_addr_0_port_1(p1_addr), .ext_dp_out_0_port_1(p1_wd), .ext_dp_in_0_port_1(p1_rd),
    .ext_dp_enable_0_port_1(p1_en), .ext_dp_write_0_port_1(p1_we)
  );

  // External dual-port RAM, read latency 1
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (p0_en) begin
      if (p0_we) ram[p0_addr] <= p0_wd;
      p0_rd <= ram[p0_addr];
    end
    if (p1_en) begin
      if (p1_we) ram[p1_addr] <= p1_wd;
      p1_rd <= ram[p1_addr];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: table contents, load progress, active buffer half
  logic [31:0] m_mem [DEPTH];
  bit m_loading = 0, m_sel = 0, m_pp = 0, m_cfg_known = 0;
  int m_cnt = 0, m_len = 0;
  logic [31:0] m_cfg_addr = 0;
  logic [31:0] m_l0 = 0, m_l1 = 0;
  bit m_k0 = 0, m_k1 = 0;
  bit use_bd = 0;
  logic [31:0] bd [256];

  typedef struct {
    int stamp;
    bit v0, v1, c0, c1;
    logic [31:0] d0, d1;
  } exp_t;
  exp_t sb [$];

  function automatic int look(input int v);
    if (m_pp) return (m_sel ? 0 : HALF) + (v % HALF);
    return v % DEPTH;
  endfunction

  function automatic int wr_index();
    if (m_pp) return (m_sel ? HALF : 0) + (m_cnt % HALF);
    return m_cnt % DEPTH;
  endfunction

  task automatic step();
    exp_t e;
    bit beat;
    databus_last_0  = m_loading && (m_cnt == m_len);
    databus_rdata_0 = use_bd ? bd[m_cnt % 256] : $urandom;
    beat = m_loading && databus_ready_0 && !rst;
    e.stamp = cyc;
    if (rst) begin
      e.v0 = 0; e.v1 = 0;
      m_l0 = 0; m_l1 = 0; m_k0 = 1; m_k1 = 1;
    end else begin
      e.v0 = running;
      e.v1 = running && !beat;
      if (e.v0) begin
        m_l0 = m_mem[look(int'(in0))];
        m_k0 = m_cfg_known && !(m_loading && !m_pp);
      end
      if (e.v1) begin
        m_l1 = m_mem[look(int'(in1))];
        m_k1 = m_cfg_known && !(m_loading && !m_pp);
      end
    end
    e.d0 = m_l0; e.c0 = m_k0;
    e.d1 = m_l1; e.c1 = m_k1;
    sb.push_back(e);
    if (rst) begin
      m_loading = 0; m_sel = 0; m_cfg_known = 0;
    end else if (beat) begin
      m_mem[wr_index()] = databus_rdata_0;
      if (m_cnt == m_len) m_loading = 0;
      m_cnt++;
    end else if (!m_loading && run && !disabled) begin
      m_loading = 1; m_cnt = 0; m_len = int'(length);
      m_cfg_addr = ext_addr; m_pp = pingPong; m_cfg_known = 1;
      if (pingPong) m_sel = !m_sel;
    end
    @(posedge clk);
    #1;
    check("done", done, {31'd0, !m_loading});
    check("valid_0", databus_valid_0, {31'd0, m_loading});
    if (m_loading) begin
      check("addr_0", databus_addr_0, m_cfg_addr);
      check("len_0", databus_len_0, m_len);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      me = sb.pop_front();
      check("out0_valid", out0_valid, {31'd0, me.v0});
      check("out1_valid", out1_valid, {31'd0, me.v1});
      if (me.c0) check("out0", out0, me.d0);
      if (me.c1) check("out1", out1, me.d1);
    end
  end

  task automatic do_load(input logic [31:0] a, input int len, input bit pp, input int stall_at,
                         input int stall_n, input bit sweep, input int rdy_pct, input int rst_at);
    int i;
    run = 1; disabled = 0; pingPong = pp; length = LW'(len); ext_addr = a;
    databus_ready_0 = 0;
    step();
    run = 0;
    i = 0;
    while (m_loading && i < 5000) begin
      ext_addr = $urandom; length = LW'($urandom); pingPong = $urandom_range(0, 1);
      run = ($urandom_range(0, 9) == 0);
      databus_ready_0 = (i >= stall_at && i < stall_at + stall_n) ? 1'b0
                        : ($urandom_range(0, 99) < rdy_pct);
      in0 = sweep ? AW'(i % DEPTH) : AW'($urandom);
      in1 = AW'($urandom);
      rst = (i == rst_at);
      step();
      i++;
    end
    rst = 0; run = 0;
    if (m_loading) begin
      check("load_timeout", 1, 0);
      m_loading = 0;
    end
  endtask

  task automatic idle_lookups(input int n, input bit rnd_running);
    for (int k = 0; k < n; k++) begin
      running = rnd_running ? 1'($urandom_range(0, 1)) : 1'b1;
      in0 = AW'($urandom); in1 = AW'($urandom);
      databus_ready_0 = $urandom_range(0, 1);
      step();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) begin ram[k] = 0; m_mem[k] = 0; end
    rst = 1; run = 0; running = 0; pingPong = 0; disabled = 0; ext_addr = 0; length = 0;
    in0 = 0; in1 = 0; databus_ready_0 = 0; databus_last_0 = 0; databus_rdata_0 = 0;
    step(); step();
    rst = 0;
    step();
    check("wdata_tied", databus_wdata_0, 0);
    check("wstrb_tied", {28'd0, databus_wstrb_0}, 0);

    // disabled run is a no-op
    run = 1; disabled = 1; pingPong = 1; step();
    run = 0; disabled = 0; step(); step();

    // plain load 0x11..0x44, then lookups
    use_bd = 1;
    for (int k = 0; k < 256; k++) bd[k] = 32'h11 * (k + 1);
    running = 1;
    do_load(32'h100, 3, 0, 99, 0, 0, 100, -1);
    in0 = 2; in1 = 3; databus_ready_0 = 0; step();
    in0 = 0; in1 = 1; step();

    // ping-pong: A, then B while sweeping (reads A), then C (reads B)
    for (int k = 0; k < 256; k++) bd[k] = 32'hA0 + k;
    do_load(32'h200, 15, 1, 99, 0, 1, 100, -1);
    for (int k = 0; k < 256; k++) bd[k] = 32'hB0 + k;
    do_load(32'h300, 15, 1, 99, 0, 1, 100, -1);
    for (int k = 0; k < 256; k++) bd[k] = 32'hC0 + k;
    do_load(32'h400, 15, 1, 99, 0, 1, 60, -1);
    idle_lookups(6, 0);

    // stalled bus for 5 cycles mid-burst
    for (int k = 0; k < 256; k++) bd[k] = 32'hD00 + k;
    do_load(32'h500, 7, 1, 3, 5, 0, 100, -1);
    idle_lookups(4, 0);

    // reset on beat 2, then a clean load
    do_load(32'h600, 3, 0, 99, 0, 0, 100, 1);
    step();
    for (int k = 0; k < 256; k++) bd[k] = 32'h55 * (k + 1);
    do_load(32'h700, 3, 0, 99, 0, 0, 100, -1);
    for (int k = 0; k < 4; k++) begin
      in0 = AW'(k); in1 = AW'(3 - k); step();
    end

    // randomized loads, lookups, disabled runs and resets
    use_bd = 0;
    for (int it = 0; it < 40; it++) begin
      running = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) begin
        run = 1; disabled = 1; pingPong = $urandom_range(0, 1); step();
        run = 0; disabled = 0;
      end else begin
        do_load($urandom, $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                $urandom_range(0, 20), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                $urandom_range(40, 100), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : -1);
      end
      idle_lookups(5, 1);
    end

    running = 0;
    step(); step();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
